display_scan_driver: RTL and testbench

DISPLAY_SCAN_DRIVER -- requirements
Module: display_scan_driver

---
 rtl/display_scan_driver.sv | 161 ++++++++++++++++
 tb/tb_display_scan_driver.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : display_scan_driver
// Purpose  : Time-multiplexed driver for an 8-digit common-anode 7-segment
//            display. Each digit position gets SCAN_DIV clock cycles. The
//            first BLANK_CYC cycles of each slot are forced dark so that
//            ghosting between neighbouring digits is suppressed. The eight
//            digit codes are snapshotted once per frame, so a frame never
//            shows a mix of old and new codes.
// Ports    : clock      - system clock, rising-edge active
//            reset      - asynchronous, active-low reset
//            d1..d8     - digit codes {enable, glyph[3:0], dp_n}; d1 = pos 0
//            an         - anode selects, active-low, an[k] = position k
//            seg        - cathodes, active-low, {dp, g, f, e, d, c, b, a}
//            frame_done - one-cycle pulse after each snapshot of d1..d8
// Revision : 1.0 - initial release
// ============================================================================
module display_scan_driver #(
    parameter int SCAN_DIV  = 100000,
    parameter int BLANK_CYC = 1000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] d1,
    input  logic [5:0] d2,
    input  logic [5:0] d3,
    input  logic [5:0] d4,
    input  logic [5:0] d5,
    input  logic [5:0] d6,
    input  logic [5:0] d7,
    input  logic [5:0] d8,
    output logic [7:0] an,
    output logic [7:0] seg,
    output logic       frame_done
);

    // Prescaler is wide enough to hold SCAN_DIV-1.
    localparam int              c_PW    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [c_PW-1:0] c_LAST  = c_PW'(SCAN_DIV - 1);
    localparam logic [c_PW-1:0] c_ONE   = c_PW'(1);
    localparam logic [2:0]      c_LAST_SLOT = 3'd7;

    logic [c_PW-1:0] r_prescaler;
    logic [2:0]      r_index;
    logic [5:0]      r_shadow [0:7];
    logic [7:0]      r_an;
    logic [7:0]      r_seg;
    logic            r_frame_done;

    logic            w_tick;
    logic            w_capture;
    logic            w_past_blank;
    logic [5:0]      w_code;
    logic            w_lit;
    logic [7:0]      w_an;
    logic [7:0]      w_seg;

    // Active-high gfedcba pattern for hex glyphs 0..F.
    function automatic logic [6:0] f_glyph(input logic [3:0] idx);
        logic [6:0] pat;
        case (idx)
            4'h0:    pat = 7'h3F;
            4'h1:    pat = 7'h06;
            4'h2:    pat = 7'h5B;
            4'h3:    pat = 7'h4F;
            4'h4:    pat = 7'h66;
            4'h5:    pat = 7'h6D;
            4'h6:    pat = 7'h7D;
            4'h7:    pat = 7'h07;
            4'h8:    pat = 7'h7F;
            4'h9:    pat = 7'h6F;
            4'hA:    pat = 7'h77;
            4'hB:    pat = 7'h7C;
            4'hC:    pat = 7'h39;
            4'hD:    pat = 7'h5E;
            4'hE:    pat = 7'h79;
            default: pat = 7'h71;
        endcase
        return pat;
    endfunction

    assign w_tick    = (r_prescaler == c_LAST);
    // The snapshot is taken on the tick that ends the last slot, so the new
    // codes take effect exactly at the start of position 0.
    assign w_capture = w_tick && (r_index == c_LAST_SLOT);

    // With no blanking interval the comparison would be trivially true;
    // tie it off explicitly instead of comparing against zero.
    generate
        if (BLANK_CYC == 0) begin : g_no_blank
            assign w_past_blank = 1'b1;
        end else begin : g_blank
            localparam logic [c_PW-1:0] c_BLANK = c_PW'(BLANK_CYC);
            assign w_past_blank = (r_prescaler >= c_BLANK);
        end
    endgenerate

    assign w_code = r_shadow[r_index];
    assign w_lit  = w_code[5] && w_past_blank;

    always_comb begin
        w_an  = 8'hFF;
        w_seg = 8'hFF;
        if (w_lit) begin
            w_an  = ~(8'd1 << r_index);
            w_seg = {w_code[0], ~f_glyph(w_code[4:1])};
        end
    end

    // Scan timing: prescaler within a slot, slot index within a frame.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_prescaler <= '0;
            r_index     <= 3'd0;
        end else begin
            if (w_tick) begin
                r_prescaler <= '0;
                r_index     <= r_index + 3'd1;
            end else begin
                r_prescaler <= r_prescaler + c_ONE;
            end
        end
    end

    // Frame snapshot of the digit codes.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) begin
                r_shadow[i] <= 6'b000000;
            end
        end else if (w_capture) begin
            r_shadow[0] <= d1;
            r_shadow[1] <= d2;
            r_shadow[2] <= d3;
            r_shadow[3] <= d4;
            r_shadow[4] <= d5;
            r_shadow[5] <= d6;
            r_shadow[6] <= d7;
            r_shadow[7] <= d8;
        end
    end

    // Registered outputs; blanking on reset is asynchronous.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_an         <= 8'hFF;
            r_seg        <= 8'hFF;
            r_frame_done <= 1'b0;
        end else begin
            r_an         <= w_an;
            r_seg        <= w_seg;
            r_frame_done <= w_capture;
        end
    end

    assign an         = r_an;
    assign seg        = r_seg;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_display_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_display_scan_driver
// Purpose  : Self-checking bench for display_scan_driver (SCAN_DIV = 4,
//            BLANK_CYC = 1). A driver pushes the expected {an, seg,
//            frame_done} for every upcoming clock edge into a queue, using a
//            frame-level model (edge count since reset, modular arithmetic
//            and a snapshot array). A monitor pops and compares after each
//            rising edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_display_scan_driver;

    localparam int SCAN_DIV  = 4;
    localparam int BLANK_CYC = 1;
    localparam int FRAME     = 8 * SCAN_DIV;

    localparam logic [6:0] GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] d [8];
    logic [7:0] an;
    logic [7:0] seg;
    logic       frame_done;

    int n_cmp = 0;
    int n_err = 0;
    logic chk_en = 1'b0;

    // Model state
    logic [16:0] exp_q [$];
    logic [5:0]  shown [8];
    int          k = 0;     // rising edges since reset release

    always #5 clock = ~clock;

    display_scan_driver #(
        .SCAN_DIV  (SCAN_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .d1         (d[0]),
        .d2         (d[1]),
        .d3         (d[2]),
        .d4         (d[3]),
        .d5         (d[4]),
        .d6         (d[5]),
        .d7         (d[6]),
        .d8         (d[7]),
        .an         (an),
        .seg        (seg),
        .frame_done (frame_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Push the expected response for the next rising edge, then advance to
    // the following falling edge. Inputs are stable across that edge.
    task automatic step();
        logic [7:0] e_an, e_seg;
        logic       e_fd;
        int         pos, slot;
        logic [5:0] code;
        if (!reset) begin
            e_an  = 8'hFF;
            e_seg = 8'hFF;
            e_fd  = 1'b0;
            k     = 0;
            for (int i = 0; i < 8; i++) shown[i] = 6'd0;
        end else begin
            pos   = k % SCAN_DIV;
            slot  = (k / SCAN_DIV) % 8;
            code  = shown[slot];
            if (code[5] && pos >= BLANK_CYC) begin
                e_an  = ~(8'd1 << slot);
                e_seg = {code[0], ~GLYPH[code[4:1]]};
            end else begin
                e_an  = 8'hFF;
                e_seg = 8'hFF;
            end
            e_fd = ((k % FRAME) == FRAME - 1);
            if (e_fd) begin
                for (int i = 0; i < 8; i++) shown[i] = d[i];
            end
            k++;
        end
        exp_q.push_back({e_an, e_seg, e_fd});
        @(negedge clock);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Monitor: compare every registered output update against the queue.
    initial begin
        logic [16:0] e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if ({an, seg, frame_done} !== e) begin
                    n_err++;
                    $display("FAIL scan: got an=%h seg=%h fd=%b, expected an=%h seg=%h fd=%b (t=%0t)",
                             an, seg, frame_done, e[16:9], e[8:1], e[0], $time);
                end
            end
        end
    end

    // At most one anode may be active at any time.
    always @(negedge clock) begin
        if (chk_en) begin
            n_cmp++;
            if ($countones(~an) > 1) begin
                n_err++;
                $display("FAIL onehot_an: got an=%h, expected at most one low bit (t=%0t)", an, $time);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 8; i++) d[i] = 6'd0;
        d[0] = 6'b100011;
        #1;
        reset = 1'b0;                     // asynchronous assertion
        #1;
        chk_en = 1'b1;
        check("reset_an", {24'd0, an}, 32'h0000_00FF);
        check("reset_seg", {24'd0, seg}, 32'h0000_00FF);
        check("reset_fd", {31'd0, frame_done}, 32'h0);

        // Reset held across several edges, then release at a falling edge.
        run(4);
        reset = 1'b1;

        // Glyph scenario: positions 0..7 show glyphs 0..7 with dp off.
        for (int i = 0; i < 8; i++) d[i] = {1'b1, 4'(i), 1'b1};
        run(2 * FRAME);

        // Blank and dp scenario.
        for (int i = 0; i < 8; i++) d[i] = 6'($urandom);
        d[3] = 6'b000000;
        d[4] = 6'b110100;
        run(2 * FRAME);

        // Tearing scenario: d3 changes in the middle of a frame.
        for (int i = 0; i < 8; i++) d[i] = 6'($urandom) | 6'b100000;
        while ((k % FRAME) != 12) step();
        d[2] = {1'b1, 4'($urandom), 1'b0};
        run(2 * FRAME);

        // Inputs churning every cycle; only capture-cycle values matter.
        for (int f = 0; f < 4 * FRAME; f++) begin
            for (int i = 0; i < 8; i++) d[i] = 6'($urandom);
            step();
        end

        // Mid-frame reset while position 5 is lit.
        for (int i = 0; i < 8; i++) d[i] = 6'($urandom);
        d[5] = 6'b101011;
        run(FRAME);
        while ((k % FRAME) != 22) step();
        step();                           // edge registers slot 5, phase 2
        check("pos5_lit_an", {24'd0, an}, 32'h0000_00DF);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_an", {24'd0, an}, 32'h0000_00FF);
        check("async_rst_seg", {24'd0, seg}, 32'h0000_00FF);
        check("async_rst_fd", {31'd0, frame_done}, 32'h0);
        run(3);
        reset = 1'b1;
        for (int i = 0; i < 8; i++) d[i] = 6'($urandom) | 6'b100000;
        run(2 * FRAME + 5);

        @(posedge clock);
        #2;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
